// File: rtl/driver_motores.sv
// Dual-axis stepper driver: per-axis IDLE/RUN machine with step divider, 4-phase
// coil sequencing, 0..359 degree angle tracking and a settle-qualified done flag.
module driver_motores #(
  parameter int DIV    = 50000,
  parameter int SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  s_in_teta,
  input  logic [1:0]  s_in_fi,
  output logic [3:0]  fase_teta,
  output logic [3:0]  fase_fi,
  output logic        paso_teta,
  output logic        paso_fi,
  output logic [15:0] teta_actual,
  output logic [15:0] fi_actual,
  output logic        done
);

  localparam int DW = $clog2(DIV);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [8:0]    ANGLE_MAX   = 9'd359;
  localparam logic [1:0]    CMD_INC     = 2'b10;

  typedef enum logic {IDLE, RUN} state_e;

  // Index 0 is the vertical (teta) axis, index 1 the horizontal (fi) axis.
  logic [1:0]    cmd_q    [2];
  state_e        state    [2];
  state_e        state_nx [2];
  logic [DW-1:0] div_q    [2];
  logic [DW-1:0] div_nx   [2];
  logic [1:0]    phase_q  [2];
  logic [1:0]    phase_nx [2];
  logic [8:0]    angle_q  [2];
  logic [8:0]    angle_nx [2];
  logic [3:0]    fase_q   [2];
  logic [1:0]    tick;
  logic [1:0]    paso_q;
  logic [SW-1:0] settle_q;
  logic          done_q;
  logic          any_run_nx;

  function automatic logic [3:0] pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    pattern = 4'b1001;
      2'd1:    pattern = 4'b1100;
      2'd2:    pattern = 4'b0110;
      default: pattern = 4'b0011;
    endcase
  endfunction

  // Only 01 and 10 request motion; 00 and 11 both mean stop.
  function automatic logic moving(input logic [1:0] cmd);
    moving = cmd[1] ^ cmd[0];
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    tick = '0;
    for (int i = 0; i < 2; i++) begin
      state_nx[i] = state[i];
      div_nx[i]   = '0;
      phase_nx[i] = phase_q[i];
      angle_nx[i] = angle_q[i];
      case (state[i])
        IDLE: if (en && moving(cmd_q[i])) state_nx[i] = RUN;
        RUN: begin
          if (!en || !moving(cmd_q[i]))  state_nx[i] = IDLE;
          else if (div_q[i] == DIV_LAST) tick[i] = 1'b1;
          else                           div_nx[i] = div_q[i] + 1'b1;
        end
        default: state_nx[i] = IDLE;
      endcase
      // Direction is taken from the command present at the tick itself.
      if (tick[i]) begin
        if (cmd_q[i] == CMD_INC) begin
          phase_nx[i] = phase_q[i] + 2'd1;
          angle_nx[i] = (angle_q[i] == ANGLE_MAX) ? 9'd0 : angle_q[i] + 9'd1;
        end else begin
          phase_nx[i] = phase_q[i] - 2'd1;
          angle_nx[i] = (angle_q[i] == 9'd0) ? ANGLE_MAX : angle_q[i] - 9'd1;
        end
      end
    end
    any_run_nx = (state_nx[0] == RUN) || (state_nx[1] == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cmd_q[i]   <= 2'b00;
        state[i]   <= IDLE;
        div_q[i]   <= '0;
        phase_q[i] <= 2'd0;
        angle_q[i] <= 9'd0;
        fase_q[i]  <= en ? 4'b1001 : 4'b0000;
      end
      paso_q   <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cmd_q[0] <= s_in_teta;
      cmd_q[1] <= s_in_fi;
      for (int i = 0; i < 2; i++) begin
        state[i]   <= state_nx[i];
        div_q[i]   <= div_nx[i];
        phase_q[i] <= phase_nx[i];
        angle_q[i] <= angle_nx[i];
        // Disabled coils are released, but phase and angle stay remembered.
        fase_q[i]  <= en ? pattern(phase_nx[i]) : 4'b0000;
      end
      paso_q <= tick;
      if (any_run_nx) begin
        settle_q <= '0;
        done_q   <= 1'b0;
      end else if (!done_q) begin
        settle_q <= settle_q + 1'b1;
        done_q   <= (settle_q == SETTLE_LAST);
      end
    end
  end

  assign fase_teta   = fase_q[0];
  assign fase_fi     = fase_q[1];
  assign paso_teta   = paso_q[0];
  assign paso_fi     = paso_q[1];
  assign teta_actual = {7'd0, angle_q[0]};
  assign fi_actual   = {7'd0, angle_q[1]};
  assign done        = done_q;

endmodule

// File: tb/tb_driver_motores.sv
// Directed bench for driver_motores with DIV=4, SETTLE=3; expected values hand-derived.
module tb_driver_motores;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  s_in_teta, s_in_fi;
  logic [3:0]  fase_teta, fase_fi;
  logic        paso_teta, paso_fi;
  logic [15:0] teta_actual, fi_actual;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  driver_motores #(.DIV(4), .SETTLE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s_in_teta   (s_in_teta),
    .s_in_fi     (s_in_fi),
    .fase_teta   (fase_teta),
    .fase_fi     (fase_fi),
    .paso_teta   (paso_teta),
    .paso_fi     (paso_fi),
    .teta_actual (teta_actual),
    .fi_actual   (fi_actual),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; s_in_teta = 2'b00; s_in_fi = 2'b00;
    clk_n(1);
    check("rst fase_teta", 32'(fase_teta), 32'b1001);
    check("rst fase_fi", 32'(fase_fi), 32'b1001);
    check("rst teta", 32'(teta_actual), 0);
    check("rst fi", 32'(fi_actual), 0);
    check("rst paso", 32'({paso_teta, paso_fi}), 0);
    check("rst done", 32'(done), 0);
    rst = 1'b0;
    clk_n(2);
    check("settle done early", 32'(done), 0);
    clk_n(1);
    check("settle done", 32'(done), 1);

    // Increment run on teta: pulses 5, 9, 13 clocks after the command is registered.
    s_in_teta = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      clk_n(1);
      check($sformatf("inc paso k%0d", k), 32'(paso_teta), 32'(k == 6 || k == 10 || k == 14));
      if (k == 2) check("inc done drop", 32'(done), 0);
      if (k == 6)  begin check("inc teta1", 32'(teta_actual), 1); check("inc fase1", 32'(fase_teta), 32'b1100); end
      if (k == 10) begin check("inc teta2", 32'(teta_actual), 2); check("inc fase2", 32'(fase_teta), 32'b0110); end
      if (k == 14) begin check("inc teta3", 32'(teta_actual), 3); check("inc fase3", 32'(fase_teta), 32'b0011); end
    end
    s_in_teta = 2'b00;
    clk_n(6);
    check("stop teta held", 32'(teta_actual), 3);
    check("stop fase held", 32'(fase_teta), 32'b0011);
    check("stop done", 32'(done), 1);

    // Decrement from 0 wraps to 359.
    do_reset();
    s_in_teta = 2'b01;
    clk_n(6);
    check("dec paso", 32'(paso_teta), 1);
    check("dec teta wrap", 32'(teta_actual), 359);
    check("dec fase", 32'(fase_teta), 32'b0011);
    s_in_teta = 2'b00;
    clk_n(4);
    check("dec stop paso", 32'(paso_teta), 0);
    check("dec stop teta", 32'(teta_actual), 359);

    // fi axis: 0 -> 359 -> 0.
    s_in_fi = 2'b01;
    clk_n(6);
    check("fi dec paso", 32'(paso_fi), 1);
    check("fi dec wrap", 32'(fi_actual), 359);
    check("fi dec fase", 32'(fase_fi), 32'b0011);
    s_in_fi = 2'b00;
    clk_n(3);
    s_in_fi = 2'b10;
    clk_n(6);
    check("fi inc paso", 32'(paso_fi), 1);
    check("fi inc wrap", 32'(fi_actual), 0);
    check("fi inc fase", 32'(fase_fi), 32'b1001);
    check("fi teta untouched", 32'(teta_actual), 359);
    s_in_fi = 2'b00;
    clk_n(3);

    // Both axes together.
    do_reset();
    s_in_teta = 2'b10; s_in_fi = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      clk_n(1);
      check($sformatf("both paso_teta k%0d", k), 32'(paso_teta), 32'(k == 6 || k == 10));
      check($sformatf("both paso_fi k%0d", k), 32'(paso_fi), 32'(k == 6 || k == 10));
      check($sformatf("both done k%0d", k), 32'(done), 0);
    end
    check("both teta", 32'(teta_actual), 2);
    check("both fi", 32'(fi_actual), 2);

    // Disable mid-run, then re-enable.
    en = 1'b0;
    clk_n(1);
    check("dis fase_teta", 32'(fase_teta), 0);
    check("dis fase_fi", 32'(fase_fi), 0);
    for (int k = 1; k <= 6; k++) begin
      clk_n(1);
      check($sformatf("dis paso k%0d", k), 32'({paso_teta, paso_fi}), 0);
    end
    check("dis teta frozen", 32'(teta_actual), 2);
    check("dis fi frozen", 32'(fi_actual), 2);
    en = 1'b1;
    clk_n(1);
    check("ren fase_teta", 32'(fase_teta), 32'b0110);
    check("ren fase_fi", 32'(fase_fi), 32'b0110);
    check("ren done", 32'(done), 0);
    for (int k = 2; k <= 5; k++) begin
      clk_n(1);
      check($sformatf("ren paso k%0d", k), 32'(paso_teta), 32'(k == 5));
    end
    check("ren teta", 32'(teta_actual), 3);
    s_in_teta = 2'b00; s_in_fi = 2'b00;

    // Direction flip two clocks before a tick.
    do_reset();
    s_in_teta = 2'b10;
    clk_n(6);
    check("flip first paso", 32'(paso_teta), 1);
    check("flip first teta", 32'(teta_actual), 1);
    clk_n(2);
    s_in_teta = 2'b01;
    clk_n(1);
    check("flip pre paso", 32'(paso_teta), 0);
    clk_n(1);
    check("flip paso", 32'(paso_teta), 1);
    check("flip teta", 32'(teta_actual), 0);
    check("flip fase", 32'(fase_teta), 32'b1001);

    // Reset landing on a tick edge aborts the step.
    clk_n(3);
    rst = 1'b1;
    clk_n(1);
    check("abort paso", 32'(paso_teta), 0);
    check("abort teta", 32'(teta_actual), 0);
    check("abort fase", 32'(fase_teta), 32'b1001);
    check("abort done", 32'(done), 0);
    s_in_teta = 2'b00;
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      clk_n(1);
      check($sformatf("post paso k%0d", k), 32'(paso_teta), 0);
      check($sformatf("post done k%0d", k), 32'(done), 32'(k == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/driver_motores.md
DRIVER_MOTORES -- requirements
Module: driver_motores

Interface
REQ-001 SHALL have parameter DIV, default 50000: clocks per motor step (minimum 2).
REQ-002 SHALL have parameter SETTLE, default 16: consecutive idle clocks before done asserts (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: driver enable; 0 de-energizes both motors.
REQ-006 SHALL have port s_in_teta, input, 2 bits: vertical-axis command (00 stop, 01 decrement, 10 increment, 11 stop).
REQ-007 SHALL have port s_in_fi, input, 2 bits: horizontal-axis command, same encoding.
REQ-008 SHALL have port fase_teta, output, 4 bits: vertical stepper coil pattern.
REQ-009 SHALL have port fase_fi, output, 4 bits: horizontal stepper coil pattern.
REQ-010 SHALL have port paso_teta, output, 1 bit: one-clock pulse per vertical step taken.
REQ-011 SHALL have port paso_fi, output, 1 bit: one-clock pulse per horizontal step taken.
REQ-012 SHALL have port teta_actual, output, 16 bits: vertical position in degrees, 0..359.
REQ-013 SHALL have port fi_actual, output, 16 bits: horizontal position in degrees, 0..359.
REQ-014 SHALL have port done, output, 1 bit: both axes stationary and settled.

Function
REQ-015 SHALL register s_in_teta and s_in_fi once; all decisions use the registered copy (1-clock input latency).
REQ-016 SHALL run one independent two-state machine per axis: IDLE, RUN.
REQ-017 IDLE->RUN SHALL occur when en=1 and the registered command is 01 or 10; the axis divider clears to 0 on entry.
REQ-018 RUN->IDLE SHALL occur on the clock the registered command is 00 or 11, or when en=0; the divider clears, and no step is taken on that clock.
REQ-019 In RUN, the divider SHALL count 0..DIV-1; at DIV-1 it wraps to 0 and one step executes (tick).
REQ-020 Consequently, the first step SHALL occur DIV clocks after entering RUN, and subsequent steps every DIV clocks.
REQ-021 A step SHALL, on the same clock: pulse paso_* high for one clock, advance the phase index, and update the angle.
REQ-022 A direction change 01<->10 while in RUN SHALL NOT clear the divider; the new direction applies at the next tick.
REQ-023 Phase sequence, index 0..3, SHALL be 1001, 1100, 0110, 0011; increment (10) steps index +1 mod 4, decrement (01) steps -1 mod 4.
REQ-024 Increment SHALL add 1 to the angle, with 359 wrapping to 0; decrement SHALL subtract 1, with 0 wrapping to 359; upper bits stay 0.
REQ-025 In IDLE with en=1, fase_* SHALL hold the last pattern (holding torque); with en=0, fase_* SHALL be 0000, while the phase index and angle are retained.
REQ-026 Both axes ticking on the same clock SHALL each step independently; there is no arbitration.
REQ-027 done SHALL assert after both axes have been IDLE for SETTLE consecutive clocks, and SHALL deassert on the clock either axis enters RUN.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst=1 SHALL force, on the next edge: both axes to IDLE, dividers to 0, phase indices to 0, teta_actual=0, fi_actual=0, paso_*=0, done=0, registered commands to 00, and the settle counter to 0.
REQ-030 After reset, fase_* SHALL be 1001 if en=1, else 0000.
REQ-031 rst asserted mid-RUN SHALL abort any pending step; no paso pulse SHALL be emitted on the reset clock.
REQ-032 After rst deasserts with commands at 00, done SHALL rise SETTLE clocks later.

Verification (DIV=4, SETTLE=3)
REQ-033 Reset, en=1, s_in_teta=10 held for 13 clocks -> paso_teta pulses at clocks 5, 9, 13 after the command; teta_actual goes 1, 2, 3; fase_teta goes 1100, 0110, 0011.
REQ-034 teta_actual=0, s_in_teta=01 for one step -> teta_actual=359 and fase_teta=0011.
REQ-035 Angle at 359, command 10 for one step -> angle 0; apply this on fi with s_in_fi to cover both axes.
REQ-036 Both axes commanded 10 simultaneously -> paso_teta and paso_fi pulse on the same clocks, and done stays 0 throughout RUN.
REQ-037 Drop en to 0 mid-RUN -> fase_*=0000, no further pulses, angles frozen; raise en again -> the last pattern is restored and stepping restarts with a DIV-clock delay.
REQ-038 Command 10, then 01 two clocks before a tick -> that tick decrements with no extra delay; rst one clock before a tick -> no pulse, all reset values from REQ-029 apply.
